// File: rtl/setup_stim_pkg.sv
// setup_stim_pkg: shared state encoding, default timing constants and the
// expected-alarm helper for the setup-time stimulus generator.
package setup_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PERIOD_TICKS_DEF = 10;
  localparam int TICK_NS_DEF      = 5;
  localparam int TSU_NS_DEF       = 30;

  // Alarm is due when the setup margin is strictly below the requirement.
  // The 64-bit product keeps any offset width below 32 bits from overflowing.
  function automatic logic calc_alarm(
    input logic [31:0] off,
    input int          tick_ns,
    input int          tsu_ns
  );
    logic [63:0] prod;
    prod = 64'(off) * 64'(tick_ns);
    return prod < 64'(tsu_ns);
  endfunction

endpackage

// File: rtl/setup_stim_phase.sv
// setup_stim_phase: phase counter for the generated FF_CLK with
// look-ahead flags for the wrap (rise), D toggle and half-period points.
module setup_stim_phase
  import setup_stim_pkg::*;
#(
  parameter int PERIOD_TICKS = PERIOD_TICKS_DEF,
  parameter int CW           = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] off,
  output logic          wrap,
  output logic          tog,
  output logic          half
);

  localparam logic [CW-1:0] PER  = CW'(PERIOD_TICKS);
  localparam logic [CW-1:0] PMAX = CW'(PERIOD_TICKS - 1);
  localparam logic [CW-1:0] HALF = CW'(PERIOD_TICKS / 2);

  logic [CW-1:0] ph;
  logic [CW-1:0] ph_next;
  logic [CW-1:0] tgt;

  // Flags describe the coming edge: they fire when ph is about to
  // take the named value, so the owner's registers change on it.
  assign ph_next = (ph == PMAX) ? '0 : ph + CW'(1);
  assign tgt     = (off == '0) ? '0 : PER - off;
  assign wrap    = en && (ph == PMAX);
  assign tog     = en && (ph_next == tgt);
  assign half    = en && (ph_next == HALF);

  // Phase register: cleared on burst accept, advances while enabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ph <= '0;
    end else if (clr) begin
      ph <= '0;
    end else if (en) begin
      ph <= ph_next;
    end
  end

endmodule

// File: rtl/setup_stim_gen.sv
// setup_stim_gen: drives FF_CLK/D_FF with a programmed setup margin and
// the matching expected alarm. Define SETUP_STIM_SWEEP_EN to sweep margin.
module setup_stim_gen
  import setup_stim_pkg::*;
#(
  parameter int PERIOD_TICKS = PERIOD_TICKS_DEF,
  parameter int TICK_NS      = TICK_NS_DEF,
  parameter int TSU_NS       = TSU_NS_DEF,
  parameter int CW           = 8,
  parameter int NW           = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Start,
  input  logic [CW-1:0] Offset,
  input  logic [NW-1:0] N_Edges,
  output logic          Busy,
  output logic          Done,
  output logic          FF_CLK,
  output logic          D_FF,
  output logic          Expect_Alarm,
  output logic [NW-1:0] Edge_Count
);

  localparam logic [CW-1:0] PMAX = CW'(PERIOD_TICKS - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] off_q;
  logic [CW-1:0] off_clamp;
  logic [NW-1:0] n_q;
  logic          accept;
  logic          run;
  logic          active;
  logic          rise;
  logic          tog;
  logic          half;
  logic          last_edge;

  assign accept    = (state_q == IDLE) && Start;
  assign run       = (state_q == RUN);
  assign active    = run || (state_q == DRAIN);
  assign off_clamp = (Offset > PMAX) ? PMAX : Offset;
  assign last_edge = (Edge_Count + NW'(1)) == n_q;
  assign Busy      = active;
  assign Done      = (state_q == DONE);

  setup_stim_phase #(
    .PERIOD_TICKS (PERIOD_TICKS),
    .CW           (CW)
  ) u_phase (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (accept),
    .en   (active),
    .off  (off_q),
    .wrap (rise),
    .tog  (tog),
    .half (half)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: burst runs until the last rise, then drains the high half.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = (N_Edges == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rise && last_edge) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (half) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst datapath: latches, generated clock/data and expected alarm.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      off_q        <= '0;
      n_q          <= '0;
      Edge_Count   <= '0;
      FF_CLK       <= 1'b0;
      D_FF         <= 1'b0;
      Expect_Alarm <= 1'b0;
    end else begin
      if (accept) begin
        off_q      <= off_clamp;
        n_q        <= N_Edges;
        Edge_Count <= '0;
      end
      if (run && tog) begin
        D_FF <= ~D_FF;
      end
      if (run && rise) begin
        FF_CLK       <= 1'b1;
        Edge_Count   <= Edge_Count + NW'(1);
        Expect_Alarm <= calc_alarm(32'(off_q), TICK_NS, TSU_NS);
`ifdef SETUP_STIM_SWEEP_EN
        if (off_q != '0) begin
          off_q <= off_q - CW'(1);
        end
`else
        off_q <= off_q;
`endif
      end else if (half) begin
        FF_CLK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_setup_stim_gen.sv
// tb_setup_stim_gen: directed bursts with a per-edge scoreboard checking
// setup margin, alarm, edge count, FF_CLK shape and Done timing.
module tb_setup_stim_gen;

  typedef struct {
    int   setup;
    logic alarm;
    int   cnt;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic       Start;
  logic [7:0] Offset;
  logic [7:0] N_Edges;
  logic       Busy;
  logic       Done;
  logic       FF_CLK;
  logic       D_FF;
  logic       Expect_Alarm;
  logic [7:0] Edge_Count;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_d = 0;
  int   last_rise = 0;
  int   done_cnt = 0;
  logic prev_d = 1'b0;
  logic prev_ff = 1'b0;
  logic last_alarm = 1'b0;

  setup_stim_gen dut (
    .CLK          (CLK),
    .RST          (RST),
    .Start        (Start),
    .Offset       (Offset),
    .N_Edges      (N_Edges),
    .Busy         (Busy),
    .Done         (Done),
    .FF_CLK       (FF_CLK),
    .D_FF         (D_FF),
    .Expect_Alarm (Expect_Alarm),
    .Edge_Count   (Edge_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: pops one expected record per FF_CLK rise.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (D_FF !== prev_d) last_d = cyc;
      if (FF_CLK && !prev_ff) begin
        if (sb.size() == 0) begin
          chk("unexpected_rise", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("setup_ticks", cyc - last_d, e.setup);
          chk("alarm", int'(Expect_Alarm), int'(e.alarm));
          chk("edge_count", int'(Edge_Count), e.cnt);
          if (e.cnt > 1) chk("period", cyc - last_rise, 10);
        end
        last_rise = cyc;
      end
      if (!FF_CLK && prev_ff) chk("high_width", cyc - last_rise, 5);
      if (Done) done_cnt++;
    end
    prev_d  = D_FF;
    prev_ff = FF_CLK;
    cyc++;
  end

  task automatic push_exp(input int off, input int n);
    int eo;
    eo = (off > 9) ? 9 : off;
    for (int k = 1; k <= n; k++) begin
      sb.push_back('{eo, (eo * 5 < 30), k});
      last_alarm = (eo * 5 < 30);
`ifdef SETUP_STIM_SWEEP_EN
      if (eo > 0) eo--;
`endif
    end
  endtask

  task automatic burst(input int off, input int n, input bit glitch);
    int waited;
    int budget;
    bit seen;
    push_exp(off, n);
    done_cnt = 0;
    budget = n * 10 + 30;
    @(negedge CLK);
    Start   = 1'b1;
    Offset  = 8'(off);
    N_Edges = 8'(n);
    @(negedge CLK);
    Start  = 1'b0;
    waited = 1;
    chk("busy_after_accept", int'(Busy), (n != 0) ? 1 : 0);
    seen = Done;
    while (!seen && waited < budget) begin
      @(negedge CLK);
      waited++;
      if (glitch && waited == 25) begin
        Start   = 1'b1;
        Offset  = 8'd0;
        N_Edges = 8'd1;
      end
      if (glitch && waited == 26) Start = 1'b0;
      seen = Done;
    end
    chk("done_seen", int'(seen), 1);
    chk("done_latency", waited, (n == 0) ? 1 : n * 10 + 6);
    chk("busy_at_done", int'(Busy), 0);
    chk("final_edge_count", int'(Edge_Count), n);
    @(negedge CLK);
    chk("done_one_cycle", int'(Done), 0);
    @(negedge CLK);
    chk("done_pulses", done_cnt, 1);
    chk("sb_drained", sb.size(), 0);
    if (n > 0) chk("alarm_hold", int'(Expect_Alarm), int'(last_alarm));
  endtask

  initial begin
    int w;
    RST     = 1'b1;
    Start   = 1'b0;
    Offset  = 8'd0;
    N_Edges = 8'd0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_ffclk", int'(FF_CLK), 0);
    chk("rst_dff", int'(D_FF), 0);
    chk("rst_alarm", int'(Expect_Alarm), 0);
    chk("rst_count", int'(Edge_Count), 0);
    RST = 1'b0;
    @(negedge CLK);

    burst(8, 3, 1'b0);
    burst(6, 2, 1'b0);
    burst(5, 2, 1'b0);
    burst(0, 3, 1'b0);
    burst(15, 2, 1'b0);
    burst(0, 0, 1'b0);

    push_exp(5, 4);
    @(negedge CLK);
    Start   = 1'b1;
    Offset  = 8'd5;
    N_Edges = 8'd4;
    @(negedge CLK);
    Start = 1'b0;
    w = 0;
    while (Edge_Count != 8'd2 && w < 60) begin
      @(negedge CLK);
      w++;
    end
    chk("reach_count2", int'(Edge_Count), 2);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_busy", int'(Busy), 0);
    chk("mid_rst_done", int'(Done), 0);
    chk("mid_rst_ffclk", int'(FF_CLK), 0);
    chk("mid_rst_dff", int'(D_FF), 0);
    chk("mid_rst_alarm", int'(Expect_Alarm), 0);
    chk("mid_rst_count", int'(Edge_Count), 0);
    sb.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    burst(8, 2, 1'b0);

    burst(8, 8, 1'b1);
    repeat (20) @(negedge CLK);
    chk("idle_busy", int'(Busy), 0);
    chk("idle_ffclk", int'(FF_CLK), 0);
    chk("idle_sb", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/setup_stim_gen.md
Name: setup_stim_gen

Overview:
- Stimulus-side counterpart to the FF setup-time monitor.
- Generates a flip-flop clock (FF_CLK) and a data line (D_FF) that toggles a programmed number of CLK ticks before each FF_CLK rising edge.
- Also emits the alarm value a correct monitor must report for each edge (Expect_Alarm), so benches can drive and self-check the monitor directly.
- Sits in the Tarea3 testbench tree between the probador and the monitor.

Parameters:
PERIOD_TICKS, 10, FF_CLK period in CLK cycles; even, >= 4
TICK_NS, 5, CLK period in ns, used only for the expectation compare
TSU_NS, 30, required setup time in ns
CW, 8, width of Offset and the phase counter
NW, 8, width of N_Edges and Edge_Count

Ports:
CLK  input  1  generator clock (tick)
RST  input  1  reset; asynchronous, active-high
Start  input  1  request a burst; sampled only in IDLE
Offset  input  CW  ticks between the D_FF toggle and the FF_CLK rise
N_Edges  input  NW  number of FF_CLK rising edges in the burst
Busy  output  1  high from burst accept until Done
Done  output  1  one-cycle pulse at end of burst
FF_CLK  output  1  generated flip-flop clock
D_FF  output  1  generated data line
Expect_Alarm  output  1  expected monitor alarm for the latest FF_CLK rise
Edge_Count  output  NW  number of FF_CLK rises issued in the current burst

Behaviour:
- Reset (async, any time, including mid-burst):
  - All outputs go to 0, the state goes to IDLE, ph goes to 0, and the latched values clear.
  - After release, the block waits in IDLE for Start.
- States:
  - IDLE -> RUN on Start=1. On accept: latch Offset clamped to PERIOD_TICKS-1, latch N_Edges, ph<=0, Edge_Count<=0, Busy<=1.
  - IDLE with Start=1 and N_Edges=0 -> DONE directly; no edges are issued.
  - RUN: ph counts 0..PERIOD_TICKS-1 and wraps.
    - A "rise" is the CLK edge where ph wraps from PERIOD_TICKS-1 to 0.
    - FF_CLK goes to 1 on each rise and stays high for PERIOD_TICKS/2 cycles, then goes to 0.
    - FF_CLK stays 0 throughout the first period after accept, so the first rise is PERIOD_TICKS cycles after accept.
  - RUN -> DRAIN after the N_Edges-th rise.
  - DRAIN: finish the high half of FF_CLK. On the cycle FF_CLK falls -> DONE.
  - DONE: Done=1 and Busy=0 for one cycle, then -> IDLE.
- D_FF timing:
  - Registered; inverts on the CLK edge where ph becomes (PERIOD_TICKS-Offset) mod PERIOD_TICKS. This happens every period in RUN, including the period before the first rise.
  - Offset=0: D_FF inverts on the same CLK edge as the FF_CLK rise, giving zero setup time.
  - D_FF holds its value through DRAIN, DONE and IDLE, and is not reset between bursts.
- Expect_Alarm:
  - Registered and updated on each rise: 1 when Offset_latched*TICK_NS < TSU_NS, else 0.
  - The comparison is strict, so exactly TSU_NS gives 0.
  - The product is computed in at least CW+8 bits.
  - Holds its value after the burst until the next rise or reset.
- Edge_Count increments on each rise and holds its final value until the next accept.
- Start while Busy is ignored. Offset and N_Edges are ignored outside accept.

Optional Feature:
- Macro SETUP_STIM_SWEEP_EN.
- Defined: after each rise, Offset_latched decrements by 1, saturating at 0. The next period's D_FF toggle and the next Expect_Alarm use the decremented value. This sweeps the setup margin down to zero across one burst.
- Undefined: Offset_latched stays constant for the whole burst.

Decomposition:
- Package setup_stim_pkg holds:
  - the state encoding (IDLE, RUN, DRAIN, DONE);
  - the default PERIOD_TICKS, TICK_NS and TSU_NS constants;
  - a function that computes the expected alarm from an offset.
- Sub-module setup_stim_phase: phase counter plus wrap/toggle-point detection, instantiated once.

Test Plan:
- Offset=8, N_Edges=3 -> 3 FF_CLK rises 10 cycles apart; D_FF toggles 8 cycles before each rise; Expect_Alarm=0; Edge_Count=3; Done pulses once.
- Offset=6 (30 ns exactly) -> Expect_Alarm=0. Offset=5 (25 ns) -> Expect_Alarm=1 from the first rise.
- Offset=0 -> D_FF inverts on the same CLK edge as each rise; Expect_Alarm=1.
- Offset=15 -> clamped to 9; D_FF toggles 1 cycle after each FF_CLK rise (9 cycles before the next); Expect_Alarm=0.
- N_Edges=0 -> no FF_CLK activity; Done pulses on the cycle after accept. RST asserted mid-burst at Edge_Count=2 -> all outputs 0 immediately; a later Start runs a fresh burst.
- With SETUP_STIM_SWEEP_EN, Offset=8, N_Edges=8 -> per-edge Expect_Alarm sequence 0,0,0,1,1,1,1,1 (offsets 8..1). Start pulsed while Busy is ignored.
